// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - opcode definitions shared by the logic unit pipeline
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_SLL  = 3'd6,
        OP_SRL  = 3'd7
    } op_e;

endpackage

// File: rtl/logic_op_core.sv
// rtl/logic_op_core.sv - combinational bitwise/shift operation core
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    logic [SH_W-1:0] shamt;

    // Shifts only look at the low bits of B, so oversized amounts wrap rather than flush.
    assign shamt = B[SH_W-1:0];

    always_comb begin
        Y = '0;
        unique case (op)
            OP_AND:  Y = A & B;
            OP_OR:   Y = A | B;
            OP_XOR:  Y = A ^ B;
            OP_NAND: Y = ~(A & B);
            OP_NOR:  Y = ~(A | B);
            OP_XNOR: Y = ~(A ^ B);
            OP_SLL:  Y = A << shamt;
            OP_SRL:  Y = A >> shamt;
            default: Y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready pipelined logic unit with zero/neg flags
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             zero,
    output logic             neg
);

    logic             s1_v_q, s1_v_d;
    op_e              s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] core_y;

    // S1 may refill whenever S2 is free or draining on this same edge.
    assign in_ready = !s1_v_q || !s2_v_q || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_v_q && (!s2_v_q || out_ready);

    logic_op_core #(
        .WIDTH (WIDTH),
        .SH_W  (SH_W)
    ) u_core (
        .op (s1_op_q),
        .A  (s1_a_q),
        .B  (s1_b_q),
        .Y  (core_y)
    );

    always_comb begin
        s1_v_d  = s1_v_q;
        s1_op_d = s1_op_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s2_v_d  = s2_v_q;
        y_d     = y_q;
        zero_d  = zero_q;
        neg_d   = neg_q;

        if (s1_load) begin
            s1_v_d  = 1'b1;
            s1_op_d = op_e'(op);
            s1_a_d  = A;
            s1_b_d  = B;
        end else if (s2_load) begin
            s1_v_d  = 1'b0;
        end

        if (s2_load) begin
            s2_v_d = 1'b1;
            y_d    = core_y;
            zero_d = (core_y == '0);
            neg_d  = core_y[WIDTH-1];
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_op_q <= OP_AND;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s2_v_q  <= 1'b0;
            y_q     <= '0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
        end else begin
            s1_v_q  <= s1_v_d;
            s1_op_q <= s1_op_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s2_v_q  <= s2_v_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign out_valid = s2_v_q;
    assign Y         = y_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule
